spi_slave_byte_if: RTL and testbench

//  SPI mode-0 slave front end directly upstream of the instruction parser.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_byte_if.sv | 149 ++++++++++++++
 tb/tb_spi_slave_byte_if.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end: default sizing and FSM state encoding.
package spi_pkg;

    localparam int               SPI_WIDTH_DEF   = 8;
    localparam int               SYNC_STAGES_DEF = 2;
    localparam logic [7:0]       IDLE_BYTE_DEF   = 8'h00;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous pin, plus rise/fall pulses taken
// from a single extra flop behind the synchroniser output.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES  = SYNC_STAGES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_byte_if.sv
// SPI mode-0 slave byte interface: oversampled deserialiser with a 1-deep rx buffer
// and a tx holding register. Optional sticky overrun flag under macro SPI_RX_OVERRUN_EN.
module spi_slave_byte_if
    import spi_pkg::*;
#(
    parameter int                   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int                   SPI_WIDTH   = SPI_WIDTH_DEF,
    parameter logic [SPI_WIDTH-1:0] IDLE_BYTE   = SPI_WIDTH'(IDLE_BYTE_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_scl,
    input  logic                 spi_sdi,
    input  logic                 spi_sel,
    output logic                 spi_sdo,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_load,
    output logic                 tx_req,
    output logic                 cs_end,
    output logic                 rx_overrun
);

    localparam int CNT_W = (SPI_WIDTH > 2) ? $clog2(SPI_WIDTH) : 1;

    logic scl_sync, scl_rise, scl_fall_unused;
    logic sel_sync, sel_rise, sel_fall;
    logic sdi_sync, sdi_rise_unused, sdi_fall_unused;
    logic scl_sync_unused, sel_sync_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_scl (
        .clk(clk), .rst_n(rst_n), .din(spi_scl),
        .dout(scl_sync), .rise(scl_rise), .fall(scl_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sel (
        .clk(clk), .rst_n(rst_n), .din(spi_sel),
        .dout(sel_sync), .rise(sel_rise), .fall(sel_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .din(spi_sdi),
        .dout(sdi_sync), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    assign scl_sync_unused = scl_sync;
    assign sel_sync_unused = sel_sync;

    spi_state_e           state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [SPI_WIDTH-1:0] rx_shift, tx_shift, tx_hold;
    logic                 start, shift_en, byte_done, reload, handshake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Select is evaluated before the clock edge, so a coincident scl edge becomes bit 0.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_fall) begin
                    state_nxt = ST_SHIFT;
                    start     = 1'b1;
                    shift_en  = scl_rise;
                end
            end
            ST_SHIFT: begin
                if (sel_rise) begin
                    state_nxt = ST_IDLE;
                end else if (scl_rise) begin
                    shift_en  = 1'b1;
                    byte_done = (bit_cnt == CNT_W'(SPI_WIDTH - 1));
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign reload    = start | byte_done;
    assign handshake = rx_valid & rx_ready;
    assign spi_sdo   = tx_shift[SPI_WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            tx_hold  <= IDLE_BYTE;
            tx_req   <= 1'b0;
            cs_end   <= 1'b0;
        end else begin
            tx_req <= reload;
            cs_end <= sel_rise;

            if (shift_en) rx_shift <= {rx_shift[SPI_WIDTH-2:0], sdi_sync};

            if (start) begin
                bit_cnt  <= scl_rise ? CNT_W'(1) : '0;
                tx_shift <= scl_rise ? (tx_hold << 1) : tx_hold;
            end else if (byte_done) begin
                bit_cnt  <= '0;
                tx_shift <= tx_hold;
            end else if (shift_en) begin
                bit_cnt  <= bit_cnt + CNT_W'(1);
                tx_shift <= tx_shift << 1;
            end else if (sel_rise) begin
                bit_cnt  <= '0;
            end

            // A parser load in the same cycle as a reload takes priority over the idle refill.
            if (tx_load)     tx_hold <= tx_data;
            else if (reload) tx_hold <= IDLE_BYTE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (byte_done && (!rx_valid || handshake)) begin
            rx_data  <= {rx_shift[SPI_WIDTH-2:0], sdi_sync};
            rx_valid <= 1'b1;
        end else if (handshake) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef SPI_RX_OVERRUN_EN
    logic overrun_evt;
    assign overrun_evt = byte_done & rx_valid & ~rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           rx_overrun <= 1'b0;
        else if (overrun_evt) rx_overrun <= 1'b1;
        else if (handshake)   rx_overrun <= 1'b0;
    end
`else
    assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_byte_if.sv
// Directed bench for spi_slave_byte_if acting as an SPI mode-0 master plus parser model.
module tb_spi_slave_byte_if;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_scl = 1'b0;
    logic       spi_sdi = 1'b0;
    logic       spi_sel = 1'b1;
    logic       spi_sdo;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_req;
    logic       cs_end;
    logic       rx_overrun;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    spi_slave_byte_if dut (
        .clk(clk), .rst_n(rst_n),
        .spi_scl(spi_scl), .spi_sdi(spi_sdi), .spi_sel(spi_sel), .spi_sdo(spi_sdo),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_load(tx_load), .tx_req(tx_req),
        .cs_end(cs_end), .rx_overrun(rx_overrun)
    );

    // Event monitor: logs accepted bytes and counts pulses.
    int         rx_cnt = 0;
    int         txreq_cnt = 0;
    int         cse_cnt = 0;
    logic [7:0] rx_log [0:63];

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            rx_log[rx_cnt[5:0]] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (tx_req) txreq_cnt <= txreq_cnt + 1;
        if (cs_end) cse_cnt   <= cse_cnt + 1;
    end

    // Parser tx side: manual one-shot loads, or auto-load of C0+n on each tx_req.
    logic       auto_en = 1'b0;
    logic       man_load = 1'b0;
    logic [7:0] man_data = 8'h00;
    logic [7:0] auto_n = 8'h00;

    always @(negedge clk) begin
        if (auto_en && tx_req) begin
            tx_load <= 1'b1;
            tx_data <= 8'hC0 + auto_n;
            auto_n  <= auto_n + 8'h01;
        end else if (man_load) begin
            tx_load <= 1'b1;
            tx_data <= man_data;
        end else begin
            tx_load <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] mosi, input int n, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            spi_sdi = mosi[i];
            #50 spi_scl = 1'b1;
            miso[i] = spi_sdo;
            #50 spi_scl = 1'b0;
        end
    endtask

    task automatic sel_low();
        spi_sel = 1'b0;
        #100;
    endtask

    task automatic sel_high();
        #40 spi_sel = 1'b1;
        #200;
    endtask

    task automatic parser_load(input logic [7:0] d);
        @(posedge clk); #3;
        man_data = d;
        man_load = 1'b1;
        @(posedge clk); #3;
        man_load = 1'b0;
        @(posedge clk); #3;
    endtask

    logic [7:0] miso;
    logic [7:0] burst_rx [0:3];
    logic [7:0] burst_tx [0:3];
    logic [7:0] burst_miso [0:3];
    logic       exp_ovr;
    int         a, c, t;

    initial begin
        burst_rx = '{8'h02, 8'h01, 8'h12, 8'h34};
        burst_tx = '{8'h00, 8'hC0, 8'hC1, 8'hC2};
`ifdef SPI_RX_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        #3;
        chk("rst_sdo",      32'(spi_sdo),    32'h0);
        chk("rst_rx_data",  32'(rx_data),    32'h0);
        chk("rst_rx_valid", 32'(rx_valid),   32'h0);
        chk("rst_tx_req",   32'(tx_req),     32'h0);
        chk("rst_cs_end",   32'(cs_end),     32'h0);
        chk("rst_overrun",  32'(rx_overrun), 32'h0);
        #40 rst_n = 1'b1;
        #40;

        // 1: single byte
        a = rx_cnt; c = cse_cnt;
        sel_low();
        send_bits(8'h01, 8, miso);
        sel_high();
        chk("t1_rx_count", 32'(rx_cnt - a),   32'd1);
        chk("t1_rx_data",  32'(rx_log[a[5:0]]), 32'h01);
        chk("t1_cs_end",   32'(cse_cnt - c),  32'd1);
        chk("t1_miso",     32'(miso),         32'h00);

        // 2: preloaded reply
        parser_load(8'hA5);
        a = rx_cnt; t = txreq_cnt;
        sel_low();
        chk("t2_txreq_at_sel", 32'(txreq_cnt - t), 32'd1);
        send_bits(8'h3C, 8, miso);
        sel_high();
        chk("t2_miso",       32'(miso),            32'hA5);
        chk("t2_rx_data",    32'(rx_log[a[5:0]]),  32'h3C);
        chk("t2_txreq_total",32'(txreq_cnt - t),   32'd2);

        // 3: four-byte burst with parser reloading on each tx_req
        auto_en = 1'b1;
        a = rx_cnt;
        sel_low();
        for (int k = 0; k < 4; k++) begin
            send_bits(burst_rx[k], 8, burst_miso[k]);
            if (k < 3) #40;
        end
        sel_high();
        auto_en = 1'b0;
        chk("t3_rx_count", 32'(rx_cnt - a), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_rx%0d", k),   32'(rx_log[6'(a + k)]), 32'(burst_rx[k]));
            chk($sformatf("t3_miso%0d", k), 32'(burst_miso[k]),     32'(burst_tx[k]));
        end

        // 4: back-pressure and overrun
        rx_ready = 1'b0;
        a = rx_cnt;
        sel_low();
        send_bits(8'h11, 8, miso);
        sel_high();
        sel_low();
        send_bits(8'h22, 8, miso);
        sel_high();
        chk("t4_valid_held", 32'(rx_valid),   32'h1);
        chk("t4_data_kept",  32'(rx_data),    32'h11);
        chk("t4_overrun",    32'(rx_overrun), 32'(exp_ovr));
        rx_ready = 1'b1;
        @(negedge clk); @(negedge clk); #3;
        chk("t4_valid_drop",  32'(rx_valid),        32'h0);
        chk("t4_overrun_clr", 32'(rx_overrun),      32'h0);
        chk("t4_rx_count",    32'(rx_cnt - a),      32'd1);
        chk("t4_rx_data",     32'(rx_log[a[5:0]]),  32'h11);

        // 5: partial byte discarded
        a = rx_cnt;
        sel_low();
        send_bits(8'hF0, 5, miso);
        sel_high();
        chk("t5_partial_none", 32'(rx_cnt - a), 32'd0);
        sel_low();
        send_bits(8'h5A, 8, miso);
        sel_high();
        chk("t5_rx_count", 32'(rx_cnt - a),     32'd1);
        chk("t5_rx_data",  32'(rx_log[a[5:0]]), 32'h5A);

        // 6: reset mid-byte
        parser_load(8'h77);
        sel_low();
        send_bits(8'hFF, 3, miso);
        rst_n = 1'b0;
        #15;
        chk("t6_rst_sdo",      32'(spi_sdo),    32'h0);
        chk("t6_rst_rx_data",  32'(rx_data),    32'h0);
        chk("t6_rst_rx_valid", 32'(rx_valid),   32'h0);
        chk("t6_rst_tx_req",   32'(tx_req),     32'h0);
        chk("t6_rst_cs_end",   32'(cs_end),     32'h0);
        chk("t6_rst_overrun",  32'(rx_overrun), 32'h0);
        spi_sel = 1'b1;
        #15 rst_n = 1'b1;
        #200;
        a = rx_cnt;
        sel_low();
        send_bits(8'hFF, 8, miso);
        sel_high();
        chk("t6_rx_count", 32'(rx_cnt - a),     32'd1);
        chk("t6_rx_data",  32'(rx_log[a[5:0]]), 32'hFF);
        chk("t6_miso",     32'(miso),           32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
